// File: rtl/arbitro_alu.sv
// Round-robin arbiter that shares one combinational ALU and its flag controller
// between two requesters, holding operands for LAT cycles before capturing results.
module arbitro_alu #(
    parameter int ancho = 3,
    parameter int LAT   = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0,
    input  logic [ancho:0]   a0,
    input  logic [ancho:0]   b0,
    input  logic [1:0]       op0,
    input  logic             s0,
    input  logic             req1,
    input  logic [ancho:0]   a1,
    input  logic [ancho:0]   b1,
    input  logic [1:0]       op1,
    input  logic             s1,
    output logic             gnt0,
    output logic             gnt1,
    output logic             done0,
    output logic             done1,
    output logic [ancho:0]   res_out,
    output logic [3:0]       flags_out,
    output logic [3:0]       status,
    output logic             busy,
    output logic [ancho:0]   alu_a,
    output logic [ancho:0]   alu_b,
    output logic [1:0]       alu_op,
    input  logic [ancho:0]   alu_res,
    input  logic             alu_n,
    input  logic             alu_z,
    input  logic             alu_c,
    input  logic             alu_v
);

    localparam logic [0:0] INACTIVO = 1'b0;
    localparam logic [0:0] EJECUTA  = 1'b1;
    localparam logic [3:0] CNT_INI  = 4'(LAT - 1);

    logic [0:0]            estado;
    logic                  ultimo;
    logic                  dueno;
    logic                  s_q;
    logic [3:0]            cnt;
    logic                  gana;

    // Requester operands gathered so the winner simply indexes them.
    logic [1:0][ancho:0]   opa;
    logic [1:0][ancho:0]   opb;
    logic [1:0][1:0]       opc;
    logic [1:0]            sel_s;

    assign opa   = {a1, a0};
    assign opb   = {b1, b0};
    assign opc   = {op1, op0};
    assign sel_s = {s1, s0};

    // On a tie the requester that did not win last time goes first.
    assign gana = (req0 && req1) ? ~ultimo : req1;
    assign busy = (estado == EJECUTA);

    always_ff @(posedge clk) begin
        if (!rst) begin
            estado    <= INACTIVO;
            ultimo    <= 1'b1;
            dueno     <= 1'b0;
            s_q       <= 1'b0;
            cnt       <= 4'd0;
            gnt0      <= 1'b0;
            gnt1      <= 1'b0;
            done0     <= 1'b0;
            done1     <= 1'b0;
            alu_a     <= '0;
            alu_b     <= '0;
            alu_op    <= 2'd0;
            res_out   <= '0;
            flags_out <= 4'd0;
            status    <= 4'd0;
        end else begin
            gnt0  <= 1'b0;
            gnt1  <= 1'b0;
            done0 <= 1'b0;
            done1 <= 1'b0;
            case (estado)
                INACTIVO: begin
                    if (req0 || req1) begin
                        alu_a  <= opa[gana];
                        alu_b  <= opb[gana];
                        alu_op <= opc[gana];
                        s_q    <= sel_s[gana];
                        dueno  <= gana;
                        ultimo <= gana;
                        cnt    <= CNT_INI;
                        gnt0   <= ~gana;
                        gnt1   <= gana;
                        estado <= EJECUTA;
                    end
                end
                EJECUTA: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        res_out   <= alu_res;
                        flags_out <= {alu_n, alu_z, alu_c, alu_v};
                        if (s_q)
                            status <= {alu_n, alu_z, alu_c, alu_v};
                        done0  <= ~dueno;
                        done1  <= dueno;
                        estado <= INACTIVO;
                    end
                end
                default: estado <= INACTIVO;
            endcase
        end
    end

endmodule

// File: doc/arbitro_alu.md
Name: arbitro_alu

Overview:
- Round-robin arbiter and sequencer that shares one combinational ALU and its flag controller between two requesters.
- Per operation: grants a requester, drives the ALU for a fixed number of cycles, then captures the result and NZCV flags.
- Returns the result and flags to the owning requester and, on request, updates the architectural status register.
- Sits between the two issuing units and the ALU/flag-controller pair.

Parameters:
- ancho, 3, MSB index of data buses; every data bus is ancho+1 bits.
- LAT, 1, cycles the ALU inputs are held before sampling; legal range 1..15.

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-low reset.
- req0  in  1  request from requester 0; held until gnt0 is seen.
- a0  in  ancho+1  operand A, requester 0.
- b0  in  ancho+1  operand B, requester 0.
- op0  in  2  ALU opcode, requester 0; passed through, not interpreted.
- s0  in  1  update status register on completion, requester 0.
- req1, a1, b1, op1, s1  in  same widths  requester 1 equivalents.
- gnt0  out  1  one-cycle accept pulse to requester 0.
- gnt1  out  1  one-cycle accept pulse to requester 1.
- done0  out  1  one-cycle completion pulse to requester 0.
- done1  out  1  one-cycle completion pulse to requester 1.
- res_out  out  ancho+1  captured ALU result.
- flags_out  out  4  captured flags {N,Z,C,V}.
- status  out  4  architectural {N,Z,C,V} register.
- busy  out  1  high whenever state is not INACTIVO.
- alu_a  out  ancho+1  registered operand A to the ALU.
- alu_b  out  ancho+1  registered operand B to the ALU.
- alu_op  out  2  registered opcode to the ALU.
- alu_res  in  ancho+1  ALU result.
- alu_n, alu_z, alu_c, alu_v  in  1 each  flags from the flag controller.

Behaviour:
- Reset (rst=0 at an edge):
  - state=INACTIVO.
  - All outputs 0: alu_a, alu_b, alu_op, res_out, flags_out, status, gnt*, done*, busy.
  - Round-robin pointer ultimo=1, so requester 0 wins the first tie.
  - Counter=0; owner=0; stored s bit=0.
- States: INACTIVO, EJECUTA.
- INACTIVO, at an edge with any req high:
  - Winner selection:
    - Only one req high: that requester wins.
    - Both high: the requester other than ultimo wins.
  - Registers loaded: alu_a/alu_b/alu_op from the winner's inputs, owner=winner, stored s=winner's s, ultimo=winner, counter=LAT-1.
  - gnt<winner>=1 for exactly the following cycle; state becomes EJECUTA.
- INACTIVO with no req: hold state; gnt*=0.
- EJECUTA, counter>0: counter decrements each edge; ALU inputs held stable.
- EJECUTA, counter=0 at an edge (capture edge):
  - res_out=alu_res; flags_out={alu_n,alu_z,alu_c,alu_v}.
  - If stored s=1: status={alu_n,alu_z,alu_c,alu_v}; otherwise status unchanged.
  - done<owner>=1 for exactly the following cycle; state=INACTIVO.
- Requests are ignored in EJECUTA and at the capture edge.
- Timing:
  - Grant edge to capture edge = LAT cycles.
  - Earliest next grant = edge after capture; back-to-back throughput is one operation per LAT+1 cycles.
- Requester rule: a requester deasserts req in the cycle gnt is high, or re-asserts it for a new operation. A req still high at the next INACTIVO edge is a new request.
- res_out and flags_out hold their values until the next capture edge.
- alu_a/alu_b/alu_op keep their last values in INACTIVO.
- gnt0 and gnt1 are never high together; done0 and done1 are never high together.
- Reset mid-operation: the operation is aborted, no done is issued, status is not updated, all reset values apply.
- LAT outside 1..15 is illegal; behaviour for it is not specified.

Test Plan:
- Reset: hold rst=0 for 2 cycles with req0=req1=1 -> all outputs 0, no gnt; after release, first grant goes to requester 0.
- Single request, LAT=1, ALU stub returns alu_res=4'h8, NZCV=4'b1001:
  - req0=1, a0=4'h7, b0=4'h1, op0=0, s0=1 -> gnt0 the cycle after edge 1; alu_a=7, alu_b=1.
  - done0 the cycle after edge 2; res_out=8, flags_out=1001, status=1001.
- Tie: req0 and req1 held high continuously -> grants alternate 0,1,0,1 with one grant per LAT+1 cycles; done pulses go to the matching owner.
- Status gating: op with s1=0 and flags 0100 after status=1001 -> flags_out=0100, status remains 1001, done1 pulses.
- LAT=3: single request -> done arrives 3 edges after the grant edge; alu_a/alu_b/alu_op stable throughout; busy high for 3 cycles.
- Reset mid-operation: rst=0 one cycle after gnt0 -> no done0, status=0, busy=0; a following req1 is granted normally.
